pulse_gen_multi: RTL and testbench

Parametrised, multi-channel successor to the single-shot load pulse generator. Each channel converts a level `trigger` (a button, or a slow strobe from the wrapper) into a clean, registered `load` pulse. The pulse starts after a configurable delay, lasts a configurable width, and can auto-repeat while the trigger is held. It sits in the wrapper between synchronised board inputs and the processor's register and PC load enables.

---
 rtl/pulse_gen_pkg.sv | 22 ++
 rtl/pulse_gen_channel.sv | 99 +++++++++
 rtl/pulse_gen_multi.sv | 51 +++++
 tb/tb_pulse_gen_multi.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the multi-channel load pulse generator:
// per-channel state encoding and counter sizing.
package pulse_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_DELAY = 2'b01,
      ST_PULSE = 2'b10,
      ST_HOLD  = 2'b11
   } state_e;

   // Wide enough to hold the largest reload value; never wraps.
   function automatic int cnt_width(input int dly, input int pw, input int rpt);
      int m;
      m = 1;
      if (dly > m) m = dly;
      if (pw  > m) m = pw;
      if (rpt > m) m = rpt;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pulse_gen_channel.sv
// One trigger-to-load channel: FSM plus reloadable down-counter, with
// registered load/busy and the combinational next-load term for the OR tree.
module pulse_gen_channel
   import pulse_gen_pkg::*;
#(
   parameter int DELAY         = 1,
   parameter int PULSE_WIDTH   = 1,
   parameter int REPEAT_PERIOD = 0,
   parameter int CW            = 1
) (
   input  logic clock,
   input  logic reset_n,
   input  logic trigger,
   output logic load,
   output logic busy,
   output logic load_next
);

   localparam logic [CW-1:0] DLY_RLD = CW'(DELAY - 1);
   localparam logic [CW-1:0] PW_RLD  = CW'(PULSE_WIDTH - 1);
   localparam logic [CW-1:0] RPT_RLD = CW'(REPEAT_PERIOD > 0 ? REPEAT_PERIOD - 1 : 0);
   localparam logic [CW-1:0] ONE     = CW'(1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          load_q, load_d;
   logic          busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (trigger) begin
               state_d = ST_DELAY;
               cnt_d   = DLY_RLD;
            end
         end
         ST_DELAY: begin
            if (cnt_q == '0) begin
               state_d = ST_PULSE;
               cnt_d   = PW_RLD;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         ST_PULSE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - ONE;
            end else if (!trigger) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               state_d = ST_HOLD;
               cnt_d   = RPT_RLD;
            end
         end
         ST_HOLD: begin
            // Releasing the trigger is the only way back to IDLE.
            if (!trigger) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (REPEAT_PERIOD > 0) begin
               if (cnt_q == '0) begin
                  state_d = ST_PULSE;
                  cnt_d   = PW_RLD;
               end else begin
                  cnt_d = cnt_q - ONE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      load_d = (state_d == ST_PULSE);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         load_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         load_q  <= load_d;
         busy_q  <= busy_d;
      end
   end

   assign load      = load_q;
   assign busy      = busy_q;
   assign load_next = load_d;

endmodule

// File: rtl/pulse_gen_multi.sv
// Multi-channel load pulse generator: independent channels plus a registered
// any_load built from next-state terms so it lines up with the load bits.
module pulse_gen_multi
   import pulse_gen_pkg::*;
#(
   parameter int CHANNELS      = 4,
   parameter int DELAY         = 1,
   parameter int PULSE_WIDTH   = 1,
   parameter int REPEAT_PERIOD = 0
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] trigger,
   output logic [CHANNELS-1:0] load,
   output logic [CHANNELS-1:0] busy,
   output logic                any_load
);

   localparam int CW = cnt_width(DELAY, PULSE_WIDTH, REPEAT_PERIOD);

   logic [CHANNELS-1:0] load_next;
   logic                any_load_q, any_load_d;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      pulse_gen_channel #(
         .DELAY         (DELAY),
         .PULSE_WIDTH   (PULSE_WIDTH),
         .REPEAT_PERIOD (REPEAT_PERIOD),
         .CW            (CW)
      ) u_ch (
         .clock     (clock),
         .reset_n   (reset_n),
         .trigger   (trigger[i]),
         .load      (load[i]),
         .busy      (busy[i]),
         .load_next (load_next[i])
      );
   end

   always_comb begin
      any_load_d = |load_next;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) any_load_q <= 1'b0;
      else          any_load_q <= any_load_d;
   end

   assign any_load = any_load_q;

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed scoreboard bench: three parameterisations of pulse_gen_multi,
// expected load/busy/any_load queued per step and compared at the falling edge.
module tb_pulse_gen_multi;

   logic       clock;
   logic       reset_n;
   logic [3:0] trig_a, trig_b, trig_c;
   logic [3:0] load_a, load_b, load_c;
   logic [3:0] busy_a, busy_b, busy_c;
   logic       any_a, any_b, any_c;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int         d;
      logic [3:0] l;
      logic [3:0] b;
      logic       a;
      string      tag;
   } exp_t;

   exp_t exp_q[$];

   // Defaults
   pulse_gen_multi u_a (
      .clock(clock), .reset_n(reset_n), .trigger(trig_a),
      .load(load_a), .busy(busy_a), .any_load(any_a)
   );

   pulse_gen_multi #(.DELAY(3), .PULSE_WIDTH(4)) u_b (
      .clock(clock), .reset_n(reset_n), .trigger(trig_b),
      .load(load_b), .busy(busy_b), .any_load(any_b)
   );

   pulse_gen_multi #(.REPEAT_PERIOD(2)) u_c (
      .clock(clock), .reset_n(reset_n), .trigger(trig_c),
      .load(load_c), .busy(busy_c), .any_load(any_c)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic compare_front();
      exp_t       e;
      logic [3:0] ol, ob;
      logic       oa;
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e = exp_q.pop_front();
      case (e.d)
         0:       begin ol = load_a; ob = busy_a; oa = any_a; end
         1:       begin ol = load_b; ob = busy_b; oa = any_b; end
         default: begin ol = load_c; ob = busy_c; oa = any_c; end
      endcase
      chk({e.tag, "_load"}, {28'd0, ol}, {28'd0, e.l});
      chk({e.tag, "_busy"}, {28'd0, ob}, {28'd0, e.b});
      chk({e.tag, "_any"},  {31'd0, oa}, {31'd0, e.a});
   endtask

   task automatic step(input int d, input logic [3:0] el, input logic [3:0] eb, input string tag);
      exp_q.push_back('{d, el, eb, |el, tag});
      tick();
      compare_front();
   endtask

   initial begin
      reset_n = 1'b0;
      trig_a  = '0;
      trig_b  = '0;
      trig_c  = '0;
      @(negedge clock);

      // Reset: 3 cycles, everything quiet.
      for (int k = 0; k < 3; k++) begin
         step(0, 4'h0, 4'h0, $sformatf("rst_a%0d", k));
         step(1, 4'h0, 4'h0, $sformatf("rst_b%0d", k));
         step(2, 4'h0, 4'h0, $sformatf("rst_c%0d", k));
         // the three steps above each advanced a clock; that is harmless here
      end
      reset_n = 1'b1;
      tick();

      // 1: one-cycle trigger on channel 0 with defaults.
      trig_a = 4'b0001;
      step(0, 4'h0, 4'b0001, "t1_k0");
      trig_a = 4'b0000;
      step(0, 4'b0001, 4'b0001, "t1_k1");
      step(0, 4'h0, 4'h0, "t1_k2");
      step(0, 4'h0, 4'h0, "t1_k3");

      // 2: DELAY=3, PULSE_WIDTH=4, trigger held 20 cycles.
      trig_b = 4'b0010;
      for (int k = 0; k < 23; k++) begin
         if (k == 20) trig_b = 4'b0000;
         step(1, (k >= 3 && k <= 6) ? 4'b0010 : 4'b0000,
                 (k <= 19) ? 4'b0010 : 4'b0000, $sformatf("t2_k%0d", k));
      end

      // 3: REPEAT_PERIOD=2, held 12 cycles.
      trig_c = 4'b0100;
      for (int k = 0; k < 15; k++) begin
         if (k == 12) trig_c = 4'b0000;
         step(2, (k <= 11 && (k % 3) == 1) ? 4'b0100 : 4'b0000,
                 (k <= 11) ? 4'b0100 : 4'b0000, $sformatf("t3_k%0d", k));
      end

      // 4: toggle channel 3 every cycle; samples in DELAY/PULSE/HOLD are absorbed.
      trig_a = 4'b1000; step(0, 4'b0000, 4'b1000, "t4_k0");
      trig_a = 4'b0000; step(0, 4'b1000, 4'b1000, "t4_k1");
      trig_a = 4'b1000; step(0, 4'b0000, 4'b1000, "t4_k2");
      trig_a = 4'b0000; step(0, 4'b0000, 4'b0000, "t4_k3");
      trig_a = 4'b1000; step(0, 4'b0000, 4'b1000, "t4_k4");
      trig_a = 4'b0000; step(0, 4'b1000, 4'b1000, "t4_k5");
      step(0, 4'b0000, 4'b0000, "t4_k6");
      step(0, 4'b0000, 4'b0000, "t4_k7");

      // 5: reset during the second cycle of a 4-cycle pulse.
      trig_b = 4'b0010;
      step(1, 4'h0, 4'b0010, "t5_k0");
      trig_b = 4'b0000;
      step(1, 4'h0, 4'b0010, "t5_k1");
      step(1, 4'h0, 4'b0010, "t5_k2");
      step(1, 4'b0010, 4'b0010, "t5_k3");
      step(1, 4'b0010, 4'b0010, "t5_k4");
      reset_n = 1'b0;
      step(1, 4'h0, 4'h0, "t5_rst");
      reset_n = 1'b1;
      trig_b = 4'b0010;
      for (int k = 0; k < 9; k++) begin
         if (k == 1) trig_b = 4'b0000;
         step(1, (k >= 3 && k <= 6) ? 4'b0010 : 4'b0000,
                 (k <= 6) ? 4'b0010 : 4'b0000, $sformatf("t5_re_k%0d", k));
      end

      // 6: all channels on the same edge.
      trig_a = 4'b1111;
      step(0, 4'h0, 4'hF, "t6_k0");
      trig_a = 4'b0000;
      step(0, 4'hF, 4'hF, "t6_k1");
      step(0, 4'h0, 4'h0, "t6_k2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
